// File: rtl/plot_sink_if.sv
// Plot-stream, control and frame-buffer write signals of the plot sink.
// The slave modport is the sink side; master is the producer / testbench side.
interface plot_sink_if;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic        plotReady;
  logic        clearReq;
  logic        clearDone;
  logic        memBusy;
  logic [14:0] memAddr;
  logic [2:0]  memData;
  logic        memWren;
  logic [7:0]  clipCount;
  logic [2:0]  fifoCount;

  modport slave (
    input  x, y, color, plot, clearReq, memBusy,
    output plotReady, clearDone, memAddr, memData, memWren, clipCount, fifoCount
  );

  modport master (
    output x, y, color, plot, clearReq, memBusy,
    input  plotReady, clearDone, memAddr, memData, memWren, clipCount, fifoCount
  );
endinterface

// File: rtl/plot_sink.sv
// Pixel-plot sink: clips plots, queues them in a small FIFO and writes the
// frame buffer one pixel per cycle; also sequences full-screen clears.
module plot_sink #(
  parameter int         WIDTH       = 160,
  parameter int         HEIGHT      = 120,
  parameter int         DEPTH       = 4,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  plot_sink_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int TOTAL = WIDTH * HEIGHT;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CLR_WAIT, CLEAR} state_t;

  state_t        state;
  entry_t        fifo [DEPTH];
  entry_t        pushEnt;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [2:0]    count;
  logic [14:0]   clrCnt;
  logic          onScreen, xfer, push, pop;

  assign onScreen      = (bus.x < 8'(WIDTH)) && (bus.y < 7'(HEIGHT));
  assign bus.plotReady = (state == IDLE) && (count < 3'(DEPTH));
  assign xfer          = bus.plot && bus.plotReady;
  assign push          = xfer && onScreen;
  // Plot drain is suspended only while the clear sequencer owns the port.
  assign pop           = (state != CLEAR) && (count != 3'd0) && !bus.memBusy;
  assign bus.fifoCount = count;

  always_comb begin
    pushEnt.addr = 15'(bus.y) * 15'(WIDTH) + 15'(bus.x);
    pushEnt.data = bus.color;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wrPtr] <= pushEnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wrPtr         <= '0;
      rdPtr         <= '0;
      count         <= '0;
      clrCnt        <= '0;
      bus.memWren   <= 1'b0;
      bus.memAddr   <= '0;
      bus.memData   <= '0;
      bus.clipCount <= '0;
      bus.clearDone <= 1'b0;
    end else begin
      bus.memWren <= 1'b0;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr       <= rdPtr + 1'b1;
        bus.memWren <= 1'b1;
        bus.memAddr <= fifo[rdPtr].addr;
        bus.memData <= fifo[rdPtr].data;
      end
      count <= count + 3'(push) - 3'(pop);
      if (xfer && !onScreen && bus.clipCount != 8'hFF)
        bus.clipCount <= bus.clipCount + 8'd1;

      case (state)
        IDLE:
          if (bus.clearReq) state <= CLR_WAIT;
        CLR_WAIT:
          // Wait for the queue to empty and the last plot write to retire.
          if (count == 3'd0 && !bus.memWren) begin
            state  <= CLEAR;
            clrCnt <= '0;
          end
        CLEAR:
          // clearDone is held for one cycle after the final write, still in CLEAR.
          if (bus.clearDone) begin
            bus.clearDone <= 1'b0;
            clrCnt        <= '0;
            state         <= IDLE;
          end else if (clrCnt == 15'(TOTAL)) begin
            bus.clearDone <= 1'b1;
          end else if (!bus.memBusy) begin
            bus.memWren <= 1'b1;
            bus.memAddr <= clrCnt;
            bus.memData <= CLEAR_COLOR;
            clrCnt      <= clrCnt + 15'd1;
          end
        default:
          state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel-plot stream (x, y, color, plot) produced by the coordinate/color register logic.
- Accepts plot requests through a small FIFO and clips off-screen coordinates.
- Converts (x, y) to a linear frame-buffer address and issues single-cycle writes to the frame-buffer RAM port, honouring a busy stall.
- Also provides a full-screen clear sequencer, so screen wipes no longer need the plot stream.

Parameters:
- WIDTH, 160, visible columns; x valid range 0..WIDTH-1.
- HEIGHT, 120, visible rows; y valid range 0..HEIGHT-1.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CLEAR_COLOR, 3'b000, color written by the clear sequence.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  8  plot column.
- y  in  7  plot row.
- color  in  3  plot color.
- plot  in  1  plot request; transfer occurs when plot && plotReady are both high at a clock edge.
- plotReady  out  1  block can accept a plot this cycle.
- clearReq  in  1  request a full-screen clear; sampled only in IDLE.
- clearDone  out  1  one-cycle pulse after the last clear write.
- memBusy  in  1  frame-buffer port stall; no write may be issued while high.
- memAddr  out  15  write address = y*WIDTH + x.
- memData  out  3  write data.
- memWren  out  1  write strobe, high for exactly one cycle per write.
- clipCount  out  8  count of dropped off-screen plots; saturates at 255.
- fifoCount  out  3  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous):
  - FIFO empty; state IDLE.
  - memWren=0, memAddr=0, memData=0.
  - clipCount=0, clearDone=0, fifoCount=0, clear counter=0.
  - Any in-flight clear is abandoned.
- plotReady = (state==IDLE) && (fifoCount<DEPTH). It is combinational and does not depend on plot.
- Accept rules:
  - On an accepted transfer with x>=WIDTH or y>=HEIGHT: nothing is pushed; clipCount increments unless already 255.
  - Otherwise {addr=y*WIDTH+x, color} is pushed. The address is computed before the push with 15-bit arithmetic (max 19199).
- Drain rules:
  - In IDLE or CLR_WAIT, if the FIFO is non-empty and memBusy==0, pop the head.
  - At the next edge, memWren=1 with the popped memAddr/memData; otherwise memWren=0.
  - memAddr and memData hold their last values when memWren=0.
- Latency: an on-screen plot accepted at edge N into an empty FIFO with memBusy low produces memWren high in the cycle following edge N+1. Minimum is 1 cycle of FIFO residency plus the registered output.
- Simultaneous push and pop in the same cycle is allowed: fifoCount is unchanged, and order is preserved (strict FIFO).
- Full FIFO: plotReady=0; a plot held high is not transferred and not counted.
- FSM states: IDLE, CLR_WAIT, CLEAR.
  - IDLE: clearReq=1 -> CLR_WAIT. A plot accepted in the same cycle as clearReq is still pushed.
  - CLR_WAIT: plotReady=0; the FIFO keeps draining. When fifoCount==0 and no write is pending -> CLEAR, with clear counter=0.
  - CLEAR: plotReady=0. Each cycle with memBusy==0, issue a write with addr=counter and data=CLEAR_COLOR, then increment the counter. After the write at addr WIDTH*HEIGHT-1 (19199): clearDone=1 for one cycle and return to IDLE. clearReq is ignored outside IDLE.
- memBusy asserted mid-clear pauses the counter with no skipped or duplicated addresses. memBusy asserted while the FIFO holds data causes no pop and no loss.
- The write strobe is registered, so memWren never depends combinationally on memBusy.

Test Plan:
- Reset, then plot (x=5, y=2, color=3'b101) for one cycle with memBusy=0 -> exactly one memWren pulse, memAddr=325, memData=5, fifoCount returns to 0.
- Plots (160,0), (0,120), (159,119) -> clipCount=2; exactly one write at memAddr=19199. Then 300 off-screen plots -> clipCount saturates at 255.
- Hold memBusy=1 and stream 6 on-screen plots -> plotReady drops after 4 are accepted, fifoCount=4. Release memBusy -> 6 writes emitted in input order, no duplicates.
- clearReq with 2 plots queued -> the 2 plot writes come first, then 19200 writes at addresses 0..19199 with data 0, then a single clearDone pulse. plotReady stays 0 throughout the clear and returns to 1 the cycle after clearDone.
- Toggle memBusy every other cycle during a clear -> the address sequence stays contiguous with 19200 writes total.
- Assert reset at clear address 5000 -> all outputs return to reset values immediately. After release: state IDLE, plotReady=1, no further clear writes.
